pixel_plotter: RTL and testbench

Pixel-sweep engine that sits directly downstream of the load/plot control FSM and directly upstream of the VGA adapter. On a start pulse it does one of two things, one pixel per clock:
- latches a base coordinate and colour, then emits the SQ_SIZE×SQ_SIZE square of pixel writes anchored there;
- or, in clear mode, sweeps the whole screen with colour 0.

It reports busy and done so the control FSM can sequence successive draws.

---
 rtl/vga_params.sv | 15 +
 rtl/xy_counter.sv | 37 +++
 rtl/pixel_plotter.sv | 182 ++++++++++++++++++
 tb/tb_pixel_plotter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/vga_params.sv
// Shared VGA geometry, coordinate widths and plotter state encodings.
package vga_params;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COL_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } plot_state_t;
endpackage

// File: rtl/xy_counter.sv
// 2-D raster counter: x is the fast index, y advances when x wraps.
// Limits are run-time inputs so one instance serves both square and screen sweeps.
module xy_counter #(
  parameter int X_W = 8,
  parameter int Y_W = 7
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           en,
  input  logic [X_W-1:0] xmax,
  input  logic [Y_W-1:0] ymax,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == xmax) && (y_q == ymax);

  // Raster advance; clr has priority and returns to the origin.
  always_ff @(posedge clk) begin
    if (clr) begin
      x_q <= '0;
      y_q <= '0;
    end else if (en) begin
      if (x_q == xmax) begin
        x_q <= '0;
        y_q <= (y_q == ymax) ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/pixel_plotter.sv
// Pixel-sweep engine: draws an SQ_SIZE x SQ_SIZE square or clears the screen,
// one pixel per clock, all outputs registered.
module pixel_plotter
  import vga_params::*;
#(
  parameter int SQ_SIZE  = 4,
  parameter int SCREEN_W = vga_params::SCREEN_W,
  parameter int SCREEN_H = vga_params::SCREEN_H,
  parameter int COL_W    = vga_params::COL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic [X_W-1:0]   x_in,
  input  logic [Y_W-1:0]   y_in,
  input  logic [COL_W-1:0] col_in,
  output logic [X_W-1:0]   x_out,
  output logic [Y_W-1:0]   y_out,
  output logic [COL_W-1:0] col_out,
  output logic             plot,
  output logic             busy,
  output logic             done
);
  localparam logic [X_W-1:0] SQ_XMAX  = X_W'(SQ_SIZE - 1);
  localparam logic [Y_W-1:0] SQ_YMAX  = Y_W'(SQ_SIZE - 1);
  localparam logic [X_W-1:0] SCR_XMAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] SCR_YMAX = Y_W'(SCREEN_H - 1);
  localparam logic [X_W-1:0] X_LIM    = X_W'(SCREEN_W);
  localparam logic [Y_W-1:0] Y_LIM    = Y_W'(SCREEN_H);

  plot_state_t state_q, state_d;
  logic mode_q, mode_d;  // 1 = clear sweep
  logic fin_q, fin_d;    // final pixel is on the outputs
  logic [X_W-1:0]   xbase_q, xbase_d;
  logic [Y_W-1:0]   ybase_q, ybase_d;
  logic [COL_W-1:0] colr_q, colr_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [COL_W-1:0] col_q, col_d;
  logic plot_q, plot_d, busy_q, busy_d, done_q, done_d;

  // The counter runs one pixel ahead of the output registers: it sits at the
  // origin in IDLE, the start edge presents pixel 0 and steps it to pixel 1.
  logic           cnt_clr, cnt_en, cnt_last, mode_sel;
  logic [X_W-1:0] cnt_x, cnt_xmax;
  logic [Y_W-1:0] cnt_y, cnt_ymax;

  assign mode_sel = (state_q == ST_IDLE) ? clear : mode_q;
  assign cnt_xmax = mode_sel ? SCR_XMAX : SQ_XMAX;
  assign cnt_ymax = mode_sel ? SCR_YMAX : SQ_YMAX;

  xy_counter #(.X_W(X_W), .Y_W(Y_W)) u_cnt (
    .clk  (clk),
    .clr  (cnt_clr | reset),
    .en   (cnt_en),
    .xmax (cnt_xmax),
    .ymax (cnt_ymax),
    .x    (cnt_x),
    .y    (cnt_y),
    .last (cnt_last)
  );

  // Square pixel address: base plus offset, truncated to port width, then clipped.
  logic [X_W-1:0] src_x, sum_x;
  logic [Y_W-1:0] src_y, sum_y;
  logic           vis;
  assign src_x = (state_q == ST_IDLE) ? x_in : xbase_q;
  assign src_y = (state_q == ST_IDLE) ? y_in : ybase_q;
  assign sum_x = src_x + cnt_x;
  assign sum_y = src_y + cnt_y;
  assign vis   = (sum_x < X_LIM) && (sum_y < Y_LIM);

  // State, latches and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      fin_q   <= 1'b0;
      xbase_q <= '0;
      ybase_q <= '0;
      colr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      fin_q   <= fin_d;
      xbase_q <= xbase_d;
      ybase_q <= ybase_d;
      colr_q  <= colr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state, counter control and next output values.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    fin_d   = 1'b0;
    xbase_d = xbase_q;
    ybase_d = ybase_q;
    colr_d  = colr_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    plot_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = clear;
          busy_d = 1'b1;
          cnt_en = 1'b1;
          if (clear) begin
            state_d = ST_CLEAR;
            x_d     = '0;
            y_d     = '0;
            col_d   = '0;
            plot_d  = 1'b1;
          end else begin
            state_d = ST_DRAW;
            xbase_d = x_in;
            ybase_d = y_in;
            colr_d  = col_in;
            x_d     = sum_x;
            y_d     = sum_y;
            col_d   = col_in;
            plot_d  = vis;
          end
        end else begin
          cnt_clr = 1'b1;
        end
      end
      ST_DRAW, ST_CLEAR: begin
        busy_d = 1'b1;
        if (fin_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          fin_d  = cnt_last;
          cnt_en = !cnt_last;
          if (state_q == ST_CLEAR) begin
            x_d    = cnt_x;
            y_d    = cnt_y;
            col_d  = '0;
            plot_d = 1'b1;
          end else begin
            x_d    = sum_x;
            y_d    = sum_y;
            col_d  = colr_q;
            plot_d = vis;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign x_out   = x_q;
  assign y_out   = y_q;
  assign col_out = col_q;
  assign plot    = plot_q;
  assign busy    = busy_q;
  assign done    = done_q;
endmodule

// File: tb/tb_pixel_plotter.sv
// Self-checking bench for pixel_plotter: table of squares, random squares with
// start noise, full-screen clear, mid-operation reset.
module tb_pixel_plotter;
  localparam int SQ = 4;

  logic       clk = 1'b0;
  logic       reset, start, clear;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] col_in;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] col_out;
  logic       plot, busy, done;

  int n_chk = 0;
  int n_err = 0;

  pixel_plotter #(.SQ_SIZE(SQ)) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .x_in(x_in), .y_in(y_in), .col_in(col_in),
    .x_out(x_out), .y_out(y_out), .col_out(col_out),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x, y, c;
    int exp_plots, exp_fx, exp_fy;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Compares {x,y,col,plot,busy,done} as one word.
  task automatic chk_px(input string nm, input int ex, input int ey, input int ec,
                        input bit ep, input bit eb, input bit ed);
    logic [20:0] a, e;
    a = {x_out, y_out, col_out, plot, busy, done};
    e = {8'(ex), 7'(ey), 3'(ec), ep, eb, ed};
    chk(nm, 32'(a), 32'(e));
  endtask

  // Reference: pixel k of a square is base + (k mod S, k div S), wrapped to
  // port width, visible only inside the screen.
  task automatic do_square(input int x0, input int y0, input int c, input bit noise,
                           output int np, output int fx, output int fy);
    int ex, ey;
    bit ep;
    np = 0; fx = 0; fy = 0;
    x_in = 8'(x0); y_in = 7'(y0); col_in = 3'(c); clear = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < SQ * SQ; k++) begin
      ex = (x0 + k % SQ) % 256;
      ey = (y0 + k / SQ) % 128;
      ep = (ex < 160) && (ey < 120);
      if (k == 0) begin fx = int'(x_out); fy = int'(y_out); end
      if (plot) np++;
      chk_px($sformatf("sq_px k=%0d base=(%0d,%0d)", k, x0, y0), ex, ey, c, ep, 1'b1, 1'b0);
      if (noise) begin
        start = 1'($urandom); clear = 1'($urandom);
        x_in = 8'($urandom); y_in = 7'($urandom); col_in = 3'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0; clear = 1'b0;
    chk("sq_done pbd", 32'({plot, busy, done}), 32'(3'b011));
    @(negedge clk);
    chk("sq_idle pbd", 32'({plot, busy, done}), 32'(3'b000));
  endtask

  initial begin
    int np, fx, fy;
    tbl[0] = '{10, 20, 4, 16, 10, 20};
    tbl[1] = '{158, 118, 5, 4, 158, 118};
    tbl[2] = '{254, 126, 7, 4, 254, 126};
    tbl[3] = '{0, 0, 1, 16, 0, 0};
    tbl[4] = '{157, 0, 2, 12, 157, 0};
    tbl[5] = '{0, 117, 6, 12, 0, 117};
    tbl[6] = '{159, 119, 3, 1, 159, 119};

    reset = 1'b1; start = 1'b0; clear = 1'b0; x_in = '0; y_in = '0; col_in = '0;
    repeat (3) @(negedge clk);
    chk_px("reset_state", 0, 0, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset pbd", 32'({plot, busy, done}), 32'(3'b000));

    // Table of squares, issued back-to-back (start in the cycle after done idle).
    for (int i = 0; i < 7; i++) begin
      do_square(tbl[i].x, tbl[i].y, tbl[i].c, 1'b0, np, fx, fy);
      chk($sformatf("plots[%0d]", i), 32'(np), 32'(tbl[i].exp_plots));
      chk($sformatf("first_x[%0d]", i), 32'(fx), 32'(tbl[i].exp_fx));
      chk($sformatf("first_y[%0d]", i), 32'(fy), 32'(tbl[i].exp_fy));
    end

    // Start re-pulsed during DRAW with different x_in must be ignored.
    x_in = 8'd10; y_in = 7'd20; col_in = 3'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < SQ * SQ; k++) begin
      chk_px($sformatf("restart_px k=%0d", k), 10 + k % SQ, 20 + k / SQ, 4, 1'b1, 1'b1, 1'b0);
      if (k == 4) begin x_in = 8'd90; y_in = 7'd50; col_in = 3'd1; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
    end
    chk("restart_done pbd", 32'({plot, busy, done}), 32'(3'b011));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("restart_no_second pbd", 32'({plot, busy, done}), 32'(3'b000));
    end

    // Random squares with random input noise while busy.
    for (int i = 0; i < 12; i++)
      do_square(int'($urandom_range(255)), int'($urandom_range(127)),
                int'($urandom_range(7)), 1'b1, np, fx, fy);

    // Reset in cycle t+8 of a draw, then a full square.
    x_in = 8'd10; y_in = 7'd20; col_in = 3'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_reset busy", 32'(busy), 32'(1));
    reset = 1'b1;
    @(negedge clk);
    chk_px("midreset_outputs", 0, 0, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_idle pbd", 32'({plot, busy, done}), 32'(3'b000));
    do_square(10, 20, 4, 1'b0, np, fx, fy);
    chk("after_reset plots", 32'(np), 32'(16));

    // Full-screen clear; x_in garbage, start noise while sweeping.
    x_in = 8'd77; y_in = 7'd33; col_in = 3'd7; clear = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    for (int i = 0; i < 160 * 120; i++) begin
      chk_px($sformatf("clr_px i=%0d", i), i % 160, i / 160, 0, 1'b1, 1'b1, 1'b0);
      start = 1'($urandom_range(15) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    chk("clr_done pbd", 32'({plot, busy, done}), 32'(3'b011));
    @(negedge clk);
    chk("clr_idle pbd", 32'({plot, busy, done}), 32'(3'b000));

    // Back-to-back square right after the clear.
    do_square(100, 60, 5, 1'b0, np, fx, fy);
    chk("b2b plots", 32'(np), 32'(16));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
